// File: rtl/ram_pkg.sv
// Shared types and helpers for the masked two-port RAM.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int lane_w(input int data_w, input int lanes);
        return data_w / lanes;
    endfunction

endpackage

// File: rtl/ram_2p_masked_if.sv
// Read/write port bundle of the masked two-port RAM.
interface ram_2p_masked_if #(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 7,
    parameter int LANES  = 1
);
    logic [ADDR_W-1:0] raddr;
    logic              re;
    logic [DATA_W-1:0] rd;
    logic              rvalid;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wr;
    logic [LANES-1:0]  wmask;
    logic              we;
    logic              init_busy;

    modport master (
        output raddr, re, waddr, wr, wmask, we,
        input  rd, rvalid, init_busy
    );

    modport slave (
        input  raddr, re, waddr, wr, wmask, we,
        output rd, rvalid, init_busy
    );
endinterface

// File: rtl/ram_2p_clr_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, then hands over to normal operation.
// state | meaning
// CLEAR | writing 0 to entry[cnt] each cycle, ports blocked
// RUN   | sweep done, normal read/write
module ram_2p_clr_seq
    import ram_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              init_busy
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) state <= RUN;
                end
                RUN: state <= RUN;
                default: state <= CLEAR;
            endcase
        end
    end

    assign clr_addr  = cnt;
    assign clr_we    = (state == CLEAR);
    assign init_busy = (state == CLEAR);

endmodule

// File: rtl/ram_2p_masked.sv
// Two-port RAM with per-lane write mask and a zeroing sweep after reset.
// Define RAM_2P_BYPASS_EN to forward masked write lanes to a same-address read.
module ram_2p_masked
    import ram_pkg::*;
#(
    parameter int DATA_W = 23,
    parameter int ADDR_W = 7,
    parameter int LANES  = 1
) (
    input  logic            clk,
    input  logic            rst,
    ram_2p_masked_if.slave  bus
);

    localparam int LW    = lane_w(DATA_W, LANES);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rd_nxt;
    logic              rvalid_q;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              busy;
    logic              rd_en;

    ram_2p_clr_seq #(.ADDR_W(ADDR_W)) u_clr_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we),
        .init_busy (busy)
    );

    // Array has no reset so it maps onto a plain RAM macro.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (bus.we) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i]) mem[bus.waddr][i*LW +: LW] <= bus.wr[i*LW +: LW];
            end
        end
    end

    always_comb begin
        rd_nxt = mem[bus.raddr];
`ifdef RAM_2P_BYPASS_EN
        if (bus.we && (bus.waddr == bus.raddr)) begin
            for (int i = 0; i < LANES; i++) begin
                if (bus.wmask[i]) rd_nxt[i*LW +: LW] = bus.wr[i*LW +: LW];
            end
        end
`endif
    end

    assign rd_en = bus.re && !busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q     <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_en;
            if (rd_en) rd_q <= rd_nxt;
        end
    end

    assign bus.rd        = rd_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.init_busy = busy;

endmodule

// File: tb/tb_ram_2p_masked.sv
// Randomized self-checking bench for ram_2p_masked (32/4/4 instance plus a default-parameter instance).
module tb_ram_2p_masked;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ram_2p_masked_if #(.DATA_W(32), .ADDR_W(4), .LANES(4)) bus ();
    ram_2p_masked_if #(.DATA_W(23), .ADDR_W(7), .LANES(1)) dbus ();

    ram_2p_masked #(.DATA_W(32), .ADDR_W(4), .LANES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ram_2p_masked dut_d (
        .clk (clk),
        .rst (rst),
        .bus (dbus)
    );

`ifdef RAM_2P_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model [16];
    logic [31:0] exp_rd;

    function automatic logic [31:0] bitmask(input logic [3:0] m);
        logic [31:0] b;
        b = 32'h0;
        for (int i = 0; i < 4; i++) if (m[i]) b = b | (32'hFF << (8 * i));
        return b;
    endfunction

    // Returns the value a read would see this cycle, then applies the write.
    function automatic logic [31:0] model_step(input logic re, input logic [3:0] ra,
                                               input logic we, input logic [3:0] wa,
                                               input logic [31:0] w, input logic [3:0] m);
        logic [31:0] r;
        logic [31:0] bm;
        bm = bitmask(m);
        r  = model[ra];
        if (re && we && BYP && (ra == wa)) r = (r & ~bm) | (w & bm);
        if (we) model[wa] = (model[wa] & ~bm) | (w & bm);
        return r;
    endfunction

    task automatic drive(input logic re, input logic [3:0] ra, input logic we,
                         input logic [3:0] wa, input logic [31:0] w, input logic [3:0] m);
        bus.re    = re;
        bus.raddr = ra;
        bus.we    = we;
        bus.waddr = wa;
        bus.wr    = w;
        bus.wmask = m;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 16; a++) model[a] = 32'h0;
        exp_rd = 32'h0;
    endtask

    task automatic test_reset();
        int n;
        drive(0, 0, 0, 0, 0, 0);
        dbus.re = 0; dbus.raddr = 0; dbus.we = 0; dbus.waddr = 0; dbus.wr = 0; dbus.wmask = 0;
        #2;
        checks++; if (bus.rd !== 32'h0) begin errors++; $display("FAIL reset_rd actual=%h required=0", bus.rd); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid actual=%b required=0", bus.rvalid); end
        checks++; if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL reset_busy actual=%b required=1", bus.init_busy); end
        cycle();
        rst = 1'b1;
        n = 0;
        // Ports are hammered during the sweep; none of it may stick.
        while (bus.init_busy === 1'b1 && n < 40) begin
            drive(1, 4'($urandom_range(0, 15)), 1, 4'($urandom_range(0, 15)), $urandom, 4'hF);
            checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL clear_rvalid cycle=%0d actual=%b required=0", n, bus.rvalid); end
            cycle();
            n++;
        end
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (n != 16) begin errors++; $display("FAIL clear_length actual=%0d required=16", n); end
        checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL clear_end_rvalid actual=%b required=0", bus.rvalid); end
        model_clear();
        for (int a = 0; a < 16; a++) begin
            drive(1, 4'(a), 0, 0, 0, 0);
            cycle();
            exp_rd = model_step(1, 4'(a), 0, 0, 0, 0);
            checks++; if (bus.rd !== exp_rd || bus.rvalid !== 1'b1) begin
                errors++; $display("FAIL clear_read addr=%0d actual=%h/%b required=%h/1", a, bus.rd, bus.rvalid, exp_rd);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_mask();
        drive(0, 0, 1, 5, 32'hDEADBEEF, 4'hF); cycle(); void'(model_step(0, 0, 1, 5, 32'hDEADBEEF, 4'hF));
        drive(0, 0, 1, 5, 32'h00001100, 4'h2); cycle(); void'(model_step(0, 0, 1, 5, 32'h00001100, 4'h2));
        drive(0, 0, 1, 5, 32'hFFFFFFFF, 4'h0); cycle(); void'(model_step(0, 0, 1, 5, 32'hFFFFFFFF, 4'h0));
        drive(1, 5, 0, 0, 0, 0); cycle();
        exp_rd = model_step(1, 5, 0, 0, 0, 0);
        checks++; if (bus.rd !== 32'hDEAD11EF) begin errors++; $display("FAIL mask_read actual=%h required=DEAD11EF", bus.rd); end
        checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL mask_rvalid actual=%b required=1", bus.rvalid); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_collision();
        logic [31:0] want;
        drive(0, 0, 1, 3, 32'h11111111, 4'hF); cycle(); void'(model_step(0, 0, 1, 3, 32'h11111111, 4'hF));
        drive(1, 3, 1, 3, 32'hAAAAAAAA, 4'h5); cycle();
        exp_rd = model_step(1, 3, 1, 3, 32'hAAAAAAAA, 4'h5);
        want = BYP ? 32'h11AA11AA : 32'h11111111;
        checks++; if (bus.rd !== want) begin errors++; $display("FAIL collision_rd actual=%h required=%h", bus.rd, want); end
        drive(0, 0, 0, 0, 0, 0); cycle();
        drive(1, 3, 0, 0, 0, 0); cycle();
        exp_rd = model_step(1, 3, 0, 0, 0, 0);
        checks++; if (bus.rd !== 32'h11AA11AA) begin errors++; $display("FAIL collision_after actual=%h required=11AA11AA", bus.rd); end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_rvalid_pulse();
        logic [3:0]  wa;
        logic [31:0] w;
        logic [3:0]  m;
        drive(1, 2, 0, 0, 0, 0); cycle();
        exp_rd = model_step(1, 2, 0, 0, 0, 0);
        checks++; if (bus.rvalid !== 1'b1 || bus.rd !== exp_rd) begin
            errors++; $display("FAIL pulse_read actual=%h/%b required=%h/1", bus.rd, bus.rvalid, exp_rd);
        end
        for (int k = 0; k < 5; k++) begin
            wa = 4'($urandom_range(0, 15)); w = $urandom; m = 4'($urandom_range(0, 15));
            drive(0, 4'($urandom_range(0, 15)), 1, wa, w, m); cycle();
            void'(model_step(0, 0, 1, wa, w, m));
            checks++; if (bus.rvalid !== 1'b0 || bus.rd !== exp_rd) begin
                errors++; $display("FAIL pulse_hold k=%0d actual=%h/%b required=%h/0", k, bus.rd, bus.rvalid, exp_rd);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic        re, we;
        logic [3:0]  ra, wa, m;
        logic [31:0] w, r;
        for (int k = 0; k < 200; k++) begin
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ra = 4'($urandom_range(0, 15));
            wa = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            w  = $urandom;
            m  = 4'($urandom_range(0, 15));
            drive(re, ra, we, wa, w, m); cycle();
            r = model_step(re, ra, we, wa, w, m);
            if (re) exp_rd = r;
            checks++; if (bus.rd !== exp_rd || bus.rvalid !== re) begin
                errors++; $display("FAIL random k=%0d actual=%h/%b required=%h/%b", k, bus.rd, bus.rvalid, exp_rd, re);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        rst = 1'b0; #1;
        checks++; if (bus.rd !== 32'h0 || bus.rvalid !== 1'b0 || bus.init_busy !== 1'b1) begin
            errors++; $display("FAIL async_reset actual=%h/%b/%b required=0/0/1", bus.rd, bus.rvalid, bus.init_busy);
        end
        cycle();
        rst = 1'b1;
        repeat (7) cycle();
        checks++; if (bus.init_busy !== 1'b1) begin errors++; $display("FAIL mid_sweep_busy actual=%b required=1", bus.init_busy); end
        rst = 1'b0; #1;
        checks++; if (bus.init_busy !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++; $display("FAIL mid_reset actual=%b/%b required=1/0", bus.init_busy, bus.rvalid);
        end
        cycle();
        rst = 1'b1;
        n = 0;
        while (bus.init_busy === 1'b1 && n < 40) begin cycle(); n++; end
        checks++; if (n != 16) begin errors++; $display("FAIL resweep_length actual=%0d required=16", n); end
        model_clear();
        for (int a = 0; a < 16; a++) begin
            drive(1, 4'(a), 0, 0, 0, 0); cycle();
            exp_rd = model_step(1, 4'(a), 0, 0, 0, 0);
            checks++; if (bus.rd !== exp_rd) begin errors++; $display("FAIL resweep_read addr=%0d actual=%h required=%h", a, bus.rd, exp_rd); end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_default_params();
        int n;
        n = 0;
        while (dbus.init_busy === 1'b1 && n < 300) begin cycle(); n++; end
        checks++; if (dbus.init_busy !== 1'b0) begin errors++; $display("FAIL dflt_sweep_done actual=%b required=0", dbus.init_busy); end
        dbus.we = 1; dbus.waddr = 7'd127; dbus.wr = 23'h7FFFFF; dbus.wmask = 1'b1; cycle();
        dbus.waddr = 7'd0; dbus.wr = 23'h012345; cycle();
        dbus.we = 0; dbus.re = 1; dbus.raddr = 7'd127; cycle();
        checks++; if (dbus.rd !== 23'h7FFFFF || dbus.rvalid !== 1'b1) begin
            errors++; $display("FAIL dflt_read127 actual=%h/%b required=7fffff/1", dbus.rd, dbus.rvalid);
        end
        dbus.raddr = 7'd0; cycle();
        checks++; if (dbus.rd !== 23'h012345) begin errors++; $display("FAIL dflt_read0 actual=%h required=012345", dbus.rd); end
        dbus.raddr = 7'd64; cycle();
        checks++; if (dbus.rd !== 23'h0) begin errors++; $display("FAIL dflt_read64 actual=%h required=0", dbus.rd); end
        dbus.re = 0;
    endtask

    initial begin
        test_reset();
        test_mask();
        test_collision();
        test_rvalid_pulse();
        test_random();
        test_reset_mid_sweep();
        test_default_params();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ram_2p_masked.md
RAM_2P_MASKED -- requirements
Module: ram_2p_masked

Interface
REQ-001 SHALL have parameter DATA_W, default 23: data width in bits, 1..64.
REQ-002 SHALL have parameter ADDR_W, default 7: address width; depth DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter LANES, default 1: write-mask lanes; DATA_W divisible by LANES; lane width LW = DATA_W/LANES.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port raddr  input  ADDR_W  read address.
REQ-007 SHALL have port re  input  1  read enable.
REQ-008 SHALL have port rd  output  DATA_W  registered read data.
REQ-009 SHALL have port rvalid  output  1  rd updated this cycle.
REQ-010 SHALL have port waddr  input  ADDR_W  write address.
REQ-011 SHALL have port wr  input  DATA_W  write data.
REQ-012 SHALL have port wmask  input  LANES  per-lane write enable; bit i covers wr[i*LW +: LW].
REQ-013 SHALL have port we  input  1  write enable.
REQ-014 SHALL have port init_busy  output  1  clear sweep in progress; re/we ignored.

Function
REQ-015 SHALL implement a two-state FSM: CLEAR, RUN.
REQ-016 SHALL enter CLEAR on reset with sweep counter = 0.
REQ-017 In CLEAR, SHALL write 0 to entry[counter] each cycle and increment the counter.
REQ-018 SHALL move CLEAR->RUN on the cycle writing entry DEPTH-1; CLEAR lasts exactly DEPTH cycles after reset release.
REQ-019 init_busy SHALL equal 1 exactly while in CLEAR; in CLEAR, re and we SHALL have no effect and rvalid SHALL stay 0.
REQ-020 In RUN, we=1 SHALL update only lanes with wmask[i]=1 at waddr; we=1 with wmask=0 SHALL change nothing.
REQ-021 In RUN, re=1 at edge N SHALL load rd with entry[raddr] and set rvalid=1 after edge N (1-cycle latency).
REQ-022 rvalid SHALL be a one-cycle pulse per accepted read; back-to-back reads SHALL give rvalid=1 every cycle.
REQ-023 rd SHALL hold its last value when re=0.
REQ-024 Same-cycle re, we, raddr==waddr: result per REQ-032/REQ-033; memory SHALL always be written.
REQ-025 Different-address simultaneous read and write SHALL be independent; the read returns the pre-write contents of raddr.
REQ-026 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-027 rst=0 SHALL asynchronously force rd=0, rvalid=0, init_busy=1, FSM=CLEAR, counter=0.
REQ-028 Reset asserted during CLEAR or RUN SHALL restart the full sweep after release; no partial state survives.
REQ-029 Memory array contents SHALL NOT be reset directly; zeroing is only via the sweep.

Configuration
REQ-030 Macro RAM_2P_BYPASS_EN SHALL select collision behaviour.
REQ-031 The default mask and normal read behaviour SHALL be identical in both builds.
REQ-032 With RAM_2P_BYPASS_EN defined: on a collision, rd SHALL take wr on lanes with wmask=1 and old data on other lanes.
REQ-033 Without RAM_2P_BYPASS_EN: on a collision, rd SHALL return fully old data (read-before-write).

Structure
REQ-034 Package ram_pkg SHALL hold the FSM state encoding (CLEAR=0, RUN=1) and the lane-width helper function.
REQ-035 Sub-module ram_2p_clr_seq SHALL hold the FSM and sweep counter and output the clear address, clear write strobe and init_busy.
REQ-036 Storage SHALL be an inferable array of DEPTH x DATA_W plus one rd register; no other state.

Verification (DATA_W=32, ADDR_W=4, LANES=4 unless noted)
REQ-037 Release reset, hold re=1 -> init_busy=1 for 16 cycles, rvalid=0 throughout; then read every address -> all 0.
REQ-038 Write 0xDEADBEEF to 5 with wmask=0xF, then wmask=0x2 with wr=0x00001100 -> reading 5 gives 0xDEAD11EF one cycle after re.
REQ-039 Pre-load 3=0x11111111; same cycle re/we at 3, wr=0xAAAAAAAA, wmask=0x5 -> rd=0x11AA11AA with BYPASS_EN, 0x11111111 without; a later read gives 0x11AA11AA.
REQ-040 Reset asserted at sweep counter 7, released -> init_busy high 16 more cycles; previously written data reads 0.
REQ-041 re pulsed at 2 then held low 5 cycles -> rvalid high one cycle; rd stable for all 5.
REQ-042 Default params (23/7/1): write 0x7FFFFF at 127, read 127 -> 0x7FFFFF; write at 0 does not alter 127.
